otter_mem_arb: RTL and testbench
================================

OTTER_MEM_ARB -- requirements
Module: otter_mem_arb

Interface

Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ADDR_W, default 14, giving the memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the data width; only 32 is supported.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have RST_N, input, 1: asynchronous, active-low reset.
REQ-005 Port 1 (instruction fetch, read-only) SHALL have: req1 in 1; addr1 in 32 (byte address); gnt1 out 1; rvalid1 out 1; rdata1 out 32.
REQ-006 Port 2 (load/store) SHALL have: req2 in 1; we2 in 1; size2 in 2 (00 byte, 01 half, 10 word, 11 illegal); addr2 in 32; wdata2 in 32; gnt2 out 1; rvalid2 out 1; rdata2 out 32; err2 out 1.
REQ-007 The memory side SHALL have: mem_en out 1; mem_we out 1; mem_size out 2; mem_addr out 32; mem_wdata out 32; mem_rdata in 32. The memory is single-ported with registered reads: data is valid on the cycle after mem_en with mem_we=0.

Function

REQ-008 Grant SHALL be combinational: in the cycle gnt is high, mem_en and mem_we and mem_size and mem_addr and mem_wdata SHALL carry the granted request.
REQ-009 A requester SHALL hold req and its address, data and controls stable until it sees gnt; the arbiter SHALL tolerate req being dropped before gnt.
REQ-010 At most one of gnt1 and gnt2 SHALL be high in any cycle.
REQ-011 If only one port requests, that port SHALL be granted in the same cycle.
REQ-012 If both ports request, the port not granted most recently SHALL win (round-robin); the last-grant pointer SHALL update only on a grant.
REQ-013 Port 1 accesses SHALL be word reads: mem_we=0 and mem_size=10.
REQ-014 A port-2 request SHALL be misaligned when size2=11, or size2=01 with addr2[0]=1, or size2=10 with addr2[1:0]!=00.
REQ-015 A misaligned port-2 request SHALL still be granted (gnt2=1) but SHALL NOT drive the memory: mem_en=0.
REQ-016 The response FSM SHALL have states ST_IDLE, ST_RESP1, ST_RESP2 and ST_ERR2. The next state is set by the grant in the current cycle:
- granted port-1 read -> ST_RESP1
- granted aligned port-2 read -> ST_RESP2
- granted misaligned port-2 request -> ST_ERR2
- granted port-2 write, or no grant -> ST_IDLE
REQ-017 In ST_RESP1: rvalid1=1 and rdata1=mem_rdata.
REQ-018 In ST_RESP2: rvalid2=1 and rdata2=mem_rdata.
REQ-019 In ST_ERR2: err2=1 and rvalid2=0.
REQ-020 Each of rvalid1, rvalid2 and err2 SHALL be a one-cycle pulse.
REQ-021 Read latency SHALL be exactly 1 cycle from grant to rvalid.
REQ-022 Writes SHALL complete in the grant cycle, with no response pulse.
REQ-023 Arbitration SHALL be allowed in every state, so a new grant may coincide with the response of the previous read; sustained throughput is one access per cycle.
REQ-024 When not in the matching response state, rdata1 and rdata2 SHALL be 0.
REQ-025 When mem_en=0, mem_we, mem_size, mem_addr and mem_wdata SHALL be 0.

Reset

REQ-026 While RST_N=0, the block SHALL hold: state = ST_IDLE; last-grant pointer = port 1 (so port 2 wins the first tie); all outputs 0 immediately, independent of clk.
REQ-027 A read granted in the cycle RST_N asserts SHALL produce no rvalid after reset is released.
REQ-028 The first grant after RST_N rises SHALL be possible on the first rising clk edge's cycle.

Verification

REQ-029 Single fetch: req1=1, addr1=0x100 -> gnt1=1 and mem_addr=0x100 the same cycle; next cycle rvalid1=1 and rdata1 equals the memory word at 0x100.
REQ-030 Contention: req1 and req2 held high for 4 cycles after reset, with port-2 reads -> grants go 2,1,2,1; each rvalid follows its grant by one cycle.
REQ-031 Store: req2=1, we2=1, size2=00, addr2=0x203, wdata2=0xA5 -> gnt2=1, mem_en=1, mem_we=1, mem_size=00 the same cycle; no rvalid2 or err2 follows.
REQ-032 Misaligned access: size2=10, addr2=0x202 -> gnt2=1 and mem_en=0; next cycle err2=1 and rvalid2=0.
REQ-033 Back-to-back reads: port 2 at 0x10, then port 1 at 0x20 on consecutive cycles -> rvalid2 and then rvalid1 pulse on consecutive cycles, each with the correct data.
REQ-034 Reset mid-read: RST_N driven low in the grant cycle of a port-1 read -> all outputs 0 asynchronously; no rvalid1 after release.

Source files
------------

// File: rtl/otter_mem_arb_if.sv
// otter_mem_arb_if -- bundle of every non-clock/reset signal of otter_mem_arb.
//   Port 1 : req1, addr1 -> gnt1, rvalid1, rdata1            (fetch, read-only)
//   Port 2 : req2, we2, size2, addr2, wdata2 -> gnt2, rvalid2, rdata2, err2
//   Memory : mem_en, mem_we, mem_size, mem_addr, mem_wdata -> mem_rdata
// slave  : the arbiter's view.
// master : the view of the requesters plus the memory model around it.
interface otter_mem_arb_if #(
  parameter int DATA_W = 32
);
  logic              req1;
  logic [31:0]       addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic              req2;
  logic              we2;
  logic [1:0]        size2;
  logic [31:0]       addr2;
  logic [DATA_W-1:0] wdata2;
  logic              gnt2;
  logic              rvalid2;
  logic [DATA_W-1:0] rdata2;
  logic              err2;

  logic              mem_en;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req1, addr1, req2, we2, size2, addr2, wdata2, mem_rdata,
    output gnt1, rvalid1, rdata1, gnt2, rvalid2, rdata2, err2,
           mem_en, mem_we, mem_size, mem_addr, mem_wdata
  );

  modport master (
    output req1, addr1, req2, we2, size2, addr2, wdata2, mem_rdata,
    input  gnt1, rvalid1, rdata1, gnt2, rvalid2, rdata2, err2,
           mem_en, mem_we, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/otter_mem_arb.sv
// otter_mem_arb -- two-port round-robin arbiter in front of a single-ported,
// registered-read memory.
//   clk   : single clock, rising edge
//   RST_N : asynchronous active-low reset; forces every output to 0 at once
//   bus   : otter_mem_arb_if.slave (fetch port, load/store port, memory side)
// Grant is combinational and drives the memory in the same cycle; a granted
// read produces a one-cycle rvalid on the following cycle. Misaligned port-2
// requests are granted but never reach the memory; they return err2 instead.
module otter_mem_arb #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            RST_N,
  otter_mem_arb_if.slave  bus
);

  // Only a 32-bit data path is implemented, and a word address must fit in
  // the 32-bit byte address.
  if (DATA_W != 32 || ADDR_W > 30) begin : g_bad_param
    $error("otter_mem_arb: unsupported ADDR_W/DATA_W");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RESP1, ST_RESP2, ST_ERR2} state_t;

  state_t state, state_nxt;
  logic   last2, last2_nxt;  // 1: port 2 was the most recent grant
  logic   g1, g2, mis2;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      last2 <= 1'b0;         // port 1 "last", so port 2 wins the first tie
    end else begin
      state <= state_nxt;
      last2 <= last2_nxt;
    end
  end

  always_comb begin
    mis2 = (bus.size2 == 2'b11) ||
           (bus.size2 == 2'b01 && bus.addr2[0]) ||
           (bus.size2 == 2'b10 && bus.addr2[1:0] != 2'b00);

    // Grants are gated by RST_N so outputs fall to 0 without a clock.
    g1 = 1'b0;
    g2 = 1'b0;
    if (RST_N) begin
      if (bus.req1 && bus.req2) begin
        g2 = !last2;
        g1 = last2;
      end else begin
        g1 = bus.req1;
        g2 = bus.req2;
      end
    end

    last2_nxt = last2;
    if (g1)      last2_nxt = 1'b0;
    else if (g2) last2_nxt = 1'b1;

    state_nxt = ST_IDLE;
    if (g1)                 state_nxt = ST_RESP1;
    else if (g2 && mis2)    state_nxt = ST_ERR2;
    else if (g2 && !bus.we2) state_nxt = ST_RESP2;

    bus.gnt1      = g1;
    bus.gnt2      = g2;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_size  = 2'b00;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (g1) begin
      bus.mem_en   = 1'b1;
      bus.mem_size = 2'b10;
      bus.mem_addr = bus.addr1;
    end else if (g2 && !mis2) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.we2;
      bus.mem_size  = bus.size2;
      bus.mem_addr  = bus.addr2;
      bus.mem_wdata = bus.wdata2;
    end

    // Responses come purely from the registered state; in-flight grants
    // interleave freely with these pulses.
    bus.rvalid1 = (state == ST_RESP1);
    bus.rdata1  = (state == ST_RESP1) ? bus.mem_rdata : '0;
    bus.rvalid2 = (state == ST_RESP2);
    bus.rdata2  = (state == ST_RESP2) ? bus.mem_rdata : '0;
    bus.err2    = (state == ST_ERR2);
  end

endmodule

// File: tb/tb_otter_mem_arb.sv
module tb_otter_mem_arb;
  logic clk = 1'b0;
  logic RST_N = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  otter_mem_arb_if bus ();
  otter_mem_arb dut (.clk(clk), .RST_N(RST_N), .bus(bus));

  // Memory contents: a fixed pattern of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[17:2] ^ 16'hC35A, ~a[17:2] ^ 16'h0F0F};
  endfunction

  // Registered-read memory model.
  always @(posedge clk)
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= memf(bus.mem_addr);

  task automatic idle_inputs();
    bus.req1 = 0; bus.addr1 = 0;
    bus.req2 = 0; bus.we2 = 0; bus.size2 = 0; bus.addr2 = 0; bus.wdata2 = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    RST_N = 0;
    repeat (2) @(posedge clk);
    #2 RST_N = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.req1 = 1; bus.addr1 = 32'h80; bus.req2 = 1; bus.addr2 = 32'h90; bus.size2 = 2'b10;
    #3;
    n_chk++;
    if ({bus.gnt1, bus.gnt2, bus.rvalid1, bus.rvalid2, bus.err2, bus.mem_en, bus.mem_we} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 0",
        {bus.gnt1, bus.gnt2, bus.rvalid1, bus.rvalid2, bus.err2, bus.mem_en, bus.mem_we});
    end
    n_chk++;
    if ({bus.mem_addr, bus.mem_size, bus.rdata1, bus.rdata2} !== '0) begin
      n_fail++; $display("FAIL reset_data got addr %h rd1 %h rd2 %h exp 0", bus.mem_addr, bus.rdata1, bus.rdata2);
    end
    @(posedge clk); #1;
    n_chk++;
    if (bus.rvalid1 !== 1'b0 || bus.gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold got rvalid1 %b gnt1 %b exp 0", bus.rvalid1, bus.gnt1);
    end
    idle_inputs();
    @(posedge clk); #2 RST_N = 1;
  endtask

  task automatic test_single_fetch();
    @(posedge clk); #1;
    bus.req1 = 1; bus.addr1 = 32'h100;
    #2;
    n_chk++;
    if ({bus.gnt1, bus.gnt2, bus.mem_en, bus.mem_we, bus.mem_size} !== 6'b101010 || bus.mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL fetch_grant got g1 %b g2 %b en %b we %b sz %b addr %h exp 1 0 1 0 10 100",
        bus.gnt1, bus.gnt2, bus.mem_en, bus.mem_we, bus.mem_size, bus.mem_addr);
    end
    @(posedge clk); #1;
    idle_inputs();
    n_chk++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== memf(32'h100)) begin
      n_fail++; $display("FAIL fetch_resp got rvalid1 %b rdata1 %h exp 1 %h", bus.rvalid1, bus.rdata1, memf(32'h100));
    end
    @(posedge clk); #1;
    n_chk++;
    if (bus.rvalid1 !== 1'b0 || bus.rdata1 !== 32'h0) begin
      n_fail++; $display("FAIL fetch_pulse got rvalid1 %b rdata1 %h exp 0 0", bus.rvalid1, bus.rdata1);
    end
  endtask

  task automatic test_contention();
    int prev;
    prev = 0;
    apply_reset();
    @(posedge clk); #1;
    bus.req1 = 1; bus.addr1 = 32'h104;
    bus.req2 = 1; bus.we2 = 0; bus.size2 = 2'b10; bus.addr2 = 32'h308;
    for (int i = 0; i < 5; i++) begin
      #2;
      if (prev == 1) begin
        n_chk++;
        if (bus.rvalid1 !== 1'b1 || bus.rvalid2 !== 1'b0 || bus.rdata1 !== memf(32'h104)) begin
          n_fail++; $display("FAIL contend_resp%0d got rv1 %b rv2 %b rd1 %h exp 1 0 %h",
            i, bus.rvalid1, bus.rvalid2, bus.rdata1, memf(32'h104));
        end
      end else if (prev == 2) begin
        n_chk++;
        if (bus.rvalid2 !== 1'b1 || bus.rvalid1 !== 1'b0 || bus.rdata2 !== memf(32'h308)) begin
          n_fail++; $display("FAIL contend_resp%0d got rv1 %b rv2 %b rd2 %h exp 0 1 %h",
            i, bus.rvalid1, bus.rvalid2, bus.rdata2, memf(32'h308));
        end
      end
      if (i < 4) begin
        prev = (i % 2 == 0) ? 2 : 1;
        n_chk++;
        if ({bus.gnt1, bus.gnt2} !== ((prev == 1) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL contend_gnt%0d got %b%b exp port %0d", i, bus.gnt1, bus.gnt2, prev);
        end
      end else prev = 0;
      @(posedge clk); #1;
      if (i == 3) idle_inputs();
    end
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    bus.req2 = 1; bus.we2 = 1; bus.size2 = 2'b00; bus.addr2 = 32'h203; bus.wdata2 = 32'hA5;
    #2;
    n_chk++;
    if ({bus.gnt2, bus.mem_en, bus.mem_we, bus.mem_size} !== 5'b11100 ||
        bus.mem_addr !== 32'h203 || bus.mem_wdata !== 32'hA5) begin
      n_fail++; $display("FAIL store_grant got g2 %b en %b we %b sz %b addr %h wd %h",
        bus.gnt2, bus.mem_en, bus.mem_we, bus.mem_size, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    idle_inputs();
    n_chk++;
    if ({bus.rvalid1, bus.rvalid2, bus.err2} !== 3'b000) begin
      n_fail++; $display("FAIL store_noresp got %b exp 000", {bus.rvalid1, bus.rvalid2, bus.err2});
    end
  endtask

  task automatic test_misaligned();
    @(posedge clk); #1;
    bus.req2 = 1; bus.we2 = 0; bus.size2 = 2'b10; bus.addr2 = 32'h202;
    #2;
    n_chk++;
    if (bus.gnt2 !== 1'b1 || bus.mem_en !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_size !== 2'b00) begin
      n_fail++; $display("FAIL misalign_grant got g2 %b en %b addr %h sz %b exp 1 0 0 00",
        bus.gnt2, bus.mem_en, bus.mem_addr, bus.mem_size);
    end
    @(posedge clk); #1;
    idle_inputs();
    n_chk++;
    if (bus.err2 !== 1'b1 || bus.rvalid2 !== 1'b0 || bus.rdata2 !== 32'h0) begin
      n_fail++; $display("FAIL misalign_err got err2 %b rv2 %b rd2 %h exp 1 0 0", bus.err2, bus.rvalid2, bus.rdata2);
    end
    @(posedge clk); #1;
    n_chk++;
    if (bus.err2 !== 1'b0) begin
      n_fail++; $display("FAIL misalign_pulse got err2 %b exp 0", bus.err2);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    bus.req2 = 1; bus.we2 = 0; bus.size2 = 2'b10; bus.addr2 = 32'h10;
    @(posedge clk); #1;
    idle_inputs();
    bus.req1 = 1; bus.addr1 = 32'h20;
    #2;
    n_chk++;
    if (bus.rvalid2 !== 1'b1 || bus.rdata2 !== memf(32'h10) || bus.gnt1 !== 1'b1 || bus.mem_addr !== 32'h20) begin
      n_fail++; $display("FAIL b2b_first got rv2 %b rd2 %h g1 %b addr %h exp 1 %h 1 20",
        bus.rvalid2, bus.rdata2, bus.gnt1, bus.mem_addr, memf(32'h10));
    end
    @(posedge clk); #1;
    idle_inputs();
    n_chk++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== memf(32'h20) || bus.rvalid2 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second got rv1 %b rd1 %h rv2 %b exp 1 %h 0",
        bus.rvalid1, bus.rdata1, bus.rvalid2, memf(32'h20));
    end
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    bus.req1 = 1; bus.addr1 = 32'h40;
    #1 RST_N = 0;
    #1;
    n_chk++;
    if (bus.gnt1 !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_async got g1 %b en %b addr %h exp 0 0 0", bus.gnt1, bus.mem_en, bus.mem_addr);
    end
    @(posedge clk); #1;
    idle_inputs();
    #1 RST_N = 1;
    #1;
    n_chk++;
    if (bus.rvalid1 !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_norv got rvalid1 %b exp 0", bus.rvalid1);
    end
    // First grant right after release, then reset during the response.
    bus.req1 = 1; bus.addr1 = 32'h44;
    #1;
    n_chk++;
    if (bus.gnt1 !== 1'b1 || bus.mem_addr !== 32'h44) begin
      n_fail++; $display("FAIL rstmid_first_gnt got g1 %b addr %h exp 1 44", bus.gnt1, bus.mem_addr);
    end
    @(posedge clk); #1;
    idle_inputs();
    n_chk++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== memf(32'h44)) begin
      n_fail++; $display("FAIL rstmid_resp got rv1 %b rd1 %h exp 1 %h", bus.rvalid1, bus.rdata1, memf(32'h44));
    end
    #1 RST_N = 0;
    #1;
    n_chk++;
    if (bus.rvalid1 !== 1'b0 || bus.rdata1 !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_async_rv got rv1 %b rd1 %h exp 0 0", bus.rvalid1, bus.rdata1);
    end
    @(posedge clk); #2 RST_N = 1;
  endtask

  task automatic test_random();
    int          last;       // port granted most recently
    int          w;
    logic        mis;
    logic [2:0]  exp_flags;  // {rvalid1, rvalid2, err2}
    logic [31:0] exp_rd1, exp_rd2;
    logic [5:0]  exp_ctl;
    logic [31:0] exp_addr, exp_wd;
    apply_reset();
    last = 1;
    exp_flags = 0; exp_rd1 = 0; exp_rd2 = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({bus.rvalid1, bus.rvalid2, bus.err2} !== exp_flags ||
          bus.rdata1 !== exp_rd1 || bus.rdata2 !== exp_rd2) begin
        n_fail++; $display("FAIL rand_resp c%0d got %b %h %h exp %b %h %h", c,
          {bus.rvalid1, bus.rvalid2, bus.err2}, bus.rdata1, bus.rdata2, exp_flags, exp_rd1, exp_rd2);
      end
      bus.req1   = ($urandom_range(0, 9) < 6);
      bus.addr1  = {$urandom_range(0, 16'hFFFF), 2'b00};
      bus.req2   = ($urandom_range(0, 9) < 6);
      bus.we2    = $urandom_range(0, 1);
      bus.size2  = $urandom_range(0, 3);
      bus.addr2  = $urandom;
      bus.wdata2 = $urandom;
      #2;
      w = 0;
      if (bus.req1 && bus.req2) w = (last == 1) ? 2 : 1;
      else if (bus.req1)        w = 1;
      else if (bus.req2)        w = 2;
      mis = (bus.size2 == 3) || (bus.size2 == 1 && bus.addr2[0]) ||
            (bus.size2 == 2 && bus.addr2[1:0] != 0);
      exp_ctl = 0; exp_addr = 0; exp_wd = 0;
      exp_flags = 0; exp_rd1 = 0; exp_rd2 = 0;
      if (w == 1) begin
        exp_ctl = {2'b10, 1'b1, 1'b0, 2'b10};
        exp_addr = bus.addr1;
        exp_flags = 3'b100; exp_rd1 = memf(bus.addr1);
      end else if (w == 2 && mis) begin
        exp_ctl = 6'b010000;
        exp_flags = 3'b001;
      end else if (w == 2) begin
        exp_ctl = {2'b01, 1'b1, bus.we2, bus.size2};
        exp_addr = bus.addr2; exp_wd = bus.wdata2;
        if (!bus.we2) begin exp_flags = 3'b010; exp_rd2 = memf(bus.addr2); end
      end
      if (w != 0) last = w;
      n_chk++;
      if ({bus.gnt1, bus.gnt2, bus.mem_en, bus.mem_we, bus.mem_size} !== exp_ctl ||
          bus.mem_addr !== exp_addr || bus.mem_wdata !== exp_wd) begin
        n_fail++; $display("FAIL rand_grant c%0d got %b %h %h exp %b %h %h", c,
          {bus.gnt1, bus.gnt2, bus.mem_en, bus.mem_we, bus.mem_size}, bus.mem_addr, bus.mem_wdata,
          exp_ctl, exp_addr, exp_wd);
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
